// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
// Keymap is indexed by {row, col}; entry 0 is the top-left key.
package keypad_pkg;

    localparam int unsigned ROWS = 4;
    localparam int unsigned COLS = 4;

    typedef enum logic [1:0] {
        StScan,
        StDebounce,
        StPressed,
        StRelease
    } state_e;

    // Packed list runs from index 15 (left) down to index 0 (right).
    localparam logic [15:0][3:0] KEYMAP = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    // True when exactly one active-low row is asserted.
    function automatic logic single_low(input logic [ROWS-1:0] rows);
        logic [ROWS-1:0] act;
        act = ~rows;
        return (act != '0) && ((act & (act - 1'b1)) == '0);
    endfunction

    function automatic logic [1:0] low_row(input logic [ROWS-1:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int r = 0; r < ROWS; r++) begin
            if (!rows[r]) idx = 2'(r);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; resets to all-ones so
// idle pulled-up rows read as released.
module sync_2ff #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column drive, press/release debounce and hex encode
// with a one-cycle valid strobe.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter logic [15:0] SCAN_DIV        = 16'd1000,
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd100_000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [ROWS-1:0] row_n,
    output logic [COLS-1:0] col_n,
    output logic [1:0]      col_idx,
    output logic [3:0]      key_code,
    output logic            key_valid,
    output logic            key_held
);

    state_e          state_q, state_d;
    logic [15:0]     timer_q, timer_d;
    logic [19:0]     cnt_q, cnt_d;
    logic [1:0]      col_q, col_d;
    logic [ROWS-1:0] cand_q, cand_d;
    logic [3:0]      code_q, code_d;
    logic            valid_q, valid_d;
    logic            held_q, held_d;
    logic [ROWS-1:0] row_s;

    sync_2ff #(
        .WIDTH(ROWS)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (row_n),
        .q     (row_s)
    );

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        cand_d  = cand_q;
        code_d  = code_q;
        valid_d = 1'b0;
        held_d  = held_q;

        unique case (state_q)
            StScan: begin
                // Rows are only trusted on the last cycle of a column (settle time).
                if (timer_q == SCAN_DIV - 16'd1) begin
                    timer_d = '0;
                    if (single_low(row_s)) begin
                        cand_d  = row_s;
                        cnt_d   = '0;
                        state_d = StDebounce;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            StDebounce: begin
                if (row_s == cand_q) begin
                    if (cnt_q == DEBOUNCE_CYCLES - 20'd1) begin
                        code_d  = KEYMAP[{low_row(cand_q), col_q}];
                        valid_d = 1'b1;
                        held_d  = 1'b1;
                        state_d = StPressed;
                    end else begin
                        cnt_d = cnt_q + 20'd1;
                    end
                end else begin
                    timer_d = '0;
                    state_d = StScan;
                end
            end
            StPressed: begin
                if (row_s == '1) begin
                    cnt_d   = '0;
                    state_d = StRelease;
                end
            end
            StRelease: begin
                if (row_s == '1) begin
                    if (cnt_q == DEBOUNCE_CYCLES - 20'd1) begin
                        held_d  = 1'b0;
                        col_d   = col_q + 2'd1;
                        timer_d = '0;
                        state_d = StScan;
                    end else begin
                        cnt_d = cnt_q + 20'd1;
                    end
                end else begin
                    state_d = StPressed;
                end
            end
            default: state_d = StScan;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StScan;
            timer_q <= '0;
            cnt_q   <= '0;
            col_q   <= '0;
            cand_q  <= '1;
            code_q  <= '0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            cand_q  <= cand_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            held_q  <= held_d;
        end
    end

    assign col_n     = ~(4'b0001 << col_q);
    assign col_idx   = col_q;
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical key matrix drives the rows from the
// DUT's column drive, and a cycle model predicts every output.
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DB = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [1:0] col_idx;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] keys = '0;  // bit r*4+c set = key at row r, col c held down

    int total = 0;
    int bad = 0;
    int npulse = 0;
    logic [3:0] last_code = '0;
    logic held_at_pulse = 1'b0;

    keypad_scanner #(
        .SCAN_DIV        (16'd4),
        .DEBOUNCE_CYCLES (20'd8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_n     (row_n),
        .col_n     (col_n),
        .col_idx   (col_idx),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // Key legend read straight off the keypad face, row-major.
    function automatic logic [3:0] key_hex(input int r, input int c);
        string km;
        int v;
        km = "123A456B789CE0FD";
        v = int'(km[r*4+c]);
        return (v >= 65) ? 4'(v - 55) : 4'(v - 48);
    endfunction

    function automatic int zeros(input logic [3:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 4; i++) if (!v[i]) n++;
        return n;
    endfunction

    // Model: mode 0 scan, 1 debounce, 2 pressed, 3 release.
    int m_mode, m_tick, m_col, m_cnt;
    logic [3:0] m_cand, m_code, m_rs1, m_rs2, m_rs;
    bit m_valid, m_held;

    task automatic model_reset();
        m_mode = 0; m_tick = 0; m_col = 0; m_cnt = 0;
        m_cand = 4'hF; m_code = 4'h0; m_rs1 = 4'hF; m_rs2 = 4'hF;
        m_valid = 0; m_held = 0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                m_rs = m_rs2;
                m_valid = 0;
                case (m_mode)
                    0: begin
                        if (m_tick == SD - 1) begin
                            m_tick = 0;
                            if (zeros(m_rs) == 1) begin
                                m_cand = m_rs; m_cnt = 0; m_mode = 1;
                            end else begin
                                m_col = (m_col + 1) % 4;
                            end
                        end else begin
                            m_tick++;
                        end
                    end
                    1: begin
                        if (m_rs == m_cand) begin
                            m_cnt++;
                            if (m_cnt == DB) begin
                                for (int r = 0; r < 4; r++)
                                    if (!m_cand[r]) m_code = key_hex(r, m_col);
                                m_valid = 1; m_held = 1; m_mode = 2;
                            end
                        end else begin
                            m_mode = 0; m_tick = 0;
                        end
                    end
                    2: begin
                        if (m_rs == 4'hF) begin
                            m_cnt = 0; m_mode = 3;
                        end
                    end
                    default: begin
                        if (m_rs == 4'hF) begin
                            m_cnt++;
                            if (m_cnt == DB) begin
                                m_held = 0; m_mode = 0; m_tick = 0;
                                m_col = (m_col + 1) % 4;
                            end
                        end else begin
                            m_mode = 2;
                        end
                    end
                endcase
                m_rs2 = m_rs1;
                m_rs1 = row_n;
            end
        end
    end

    // Per-cycle compare of every output against the model.
    initial begin
        logic prev_valid;
        logic [3:0] ecol;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                ecol = ~(4'b0001 << m_col);
                check("cycle {col_n,col_idx,key_code,key_valid,key_held}",
                      {20'd0, col_n, col_idx, key_code, key_valid, key_held},
                      {20'd0, ecol, 2'(m_col), m_code, m_valid, m_held});
                if (key_valid) begin
                    npulse++;
                    last_code = key_code;
                    held_at_pulse = key_held;
                end
                if (key_valid && prev_valid) check("valid_twice", 1, 0);
                prev_valid = key_valid;
            end else begin
                prev_valid = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bit seen;

        // Model pins.
        check("model_key_r1c1", 32'(key_hex(1, 1)), 32'h5);
        check("model_key_r2c3", 32'(key_hex(2, 3)), 32'hC);
        check("model_key_r3c0", 32'(key_hex(3, 0)), 32'hE);
        check("model_key_r3c2", 32'(key_hex(3, 2)), 32'hF);

        // Reset state.
        tick(3);
        check("rst_col_n", 32'(col_n), 32'hE);
        check("rst_col_idx", 32'(col_idx), 32'h0);
        check("rst_valid", 32'(key_valid), 32'h0);
        check("rst_held", 32'(key_held), 32'h0);
        check("rst_code", 32'(key_code), 32'h0);
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            check("scan_col_idx", 32'(col_idx), 32'((k / 4) % 4));
        end

        // Clean press of "5".
        npulse = 0;
        keys[5] = 1'b1;
        tick(40);
        check("press5_pulses", 32'(npulse), 32'd1);
        check("press5_code", 32'(last_code), 32'h5);
        check("press5_held_at_pulse", 32'(held_at_pulse), 32'd1);
        check("press5_held_still", 32'(key_held), 32'd1);
        check("press5_col_frozen", 32'(col_idx), 32'd1);
        keys = '0;
        tick(30);
        check("press5_released", 32'(key_held), 32'd0);
        check("press5_single", 32'(npulse), 32'd1);

        // Bouncing "C" then held.
        npulse = 0;
        for (int i = 0; i < 10; i++) begin
            keys[11] = (i % 2 == 0);
            tick(3);
        end
        check("bounce_no_pulse", 32'(npulse), 32'd0);
        keys[11] = 1'b1;
        tick(50);
        check("bounce_pulses", 32'(npulse), 32'd1);
        check("bounce_code", 32'(last_code), 32'hC);
        keys = '0;
        tick(30);

        // Ghosting: rows 0 and 1 on column 0.
        npulse = 0;
        keys[0] = 1'b1;
        keys[4] = 1'b1;
        tick(40);
        check("ghost_no_pulse", 32'(npulse), 32'd0);
        check("ghost_not_held", 32'(key_held), 32'd0);
        keys = '0;
        tick(10);

        // Release glitch on "3".
        npulse = 0;
        keys[2] = 1'b1;
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (key_valid) seen = 1;
        end
        check("glitch_press_seen", 32'(seen), 32'd1);
        keys = '0;
        tick(4);
        keys[2] = 1'b1;
        tick(1);
        keys = '0;
        tick(7);
        check("glitch_held_kept", 32'(key_held), 32'd1);
        tick(8);
        check("glitch_held_dropped", 32'(key_held), 32'd0);
        check("glitch_pulses", 32'(npulse), 32'd1);
        check("glitch_code", 32'(last_code), 32'h3);
        tick(10);

        // Async reset while debouncing "E".
        npulse = 0;
        keys[12] = 1'b1;
        seen = 0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            if (m_mode == 1 && m_cnt >= 3) seen = 1;
        end
        check("rstmid_reached_debounce", 32'(seen), 32'd1);
        keys = '0;
        #1 rst_n = 1'b0;
        #1;
        check("rstmid_col_n", 32'(col_n), 32'hE);
        check("rstmid_col_idx", 32'(col_idx), 32'h0);
        check("rstmid_valid", 32'(key_valid), 32'h0);
        check("rstmid_held", 32'(key_held), 32'h0);
        check("rstmid_code", 32'(key_code), 32'h0);
        #1 rst_n = 1'b1;
        tick(40);
        check("rstmid_no_pulse", 32'(npulse), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Matrix-keypad front end feeding the hex encoder / register-bank write path of the calculator datapath. Drives one column of a 4x4 keypad low at a time, samples the four active-low rows through a synchronizer, debounces press and release, and emits a 4-bit hex key code with a single-cycle valid strobe. The strobe doubles as the register-bank write enable. The 2-bit column index replaces the free-running scan counter.

## Interface
- `SCAN_DIV`, 16'd1000: clock cycles each column is driven before advancing (≥2).
- `DEBOUNCE_CYCLES`, 20'd100_000: consecutive stable samples required for press and for release (≥1).

- `clk`  in  1: system clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `row_n`  in  4: keypad rows, active-low, external pull-ups, asynchronous to `clk`.
- `col_n`  out  4: column drive, one-hot active-low.
- `col_idx`  out  2: index of the driven column.
- `key_code`  out  4: hex code of the last accepted key. Held until the next accept.
- `key_valid`  out  1: one-cycle pulse on press accept.
- `key_held`  out  1: high from the accept until release debounce completes.

## Operation
- Rows pass through a 2-flop synchronizer to produce `row_s`. All decisions use `row_s`.
- A column timer counts 0..SCAN_DIV-1.
  - In SCAN it advances `col_idx` on wrap, modulo 4 (3→0).
  - `col_n = ~(4'b0001 << col_idx)`.
- States:
  - SCAN:
    - Rows are sampled only on the last timer cycle of the column (settle time).
    - If exactly one bit of `row_s` is low: latch `{row, col}` as the candidate, clear the debounce counter, go to DEBOUNCE. The column freezes.
    - All rows high: keep scanning.
    - More than one row low (ghosting): ignore and keep scanning.
  - DEBOUNCE: samples every cycle.
    - `row_s` equal to the candidate pattern: increment the counter.
    - Any other pattern: go to SCAN with the timer cleared. The column is unchanged.
    - On the DEBOUNCE_CYCLES-th match: load `key_code` from the keymap, pulse `key_valid`, set `key_held`, go to PRESSED.
  - PRESSED: column frozen.
    - When `row_s == 4'hF`: clear the counter, go to RELEASE.
  - RELEASE:
    - `row_s == 4'hF`: increment the counter.
    - Any row low: go back to PRESSED.
    - On the DEBOUNCE_CYCLES-th all-high sample: clear `key_held`, go to SCAN. Scanning resumes from the next column with the timer cleared.
- Keymap, row r / col c:
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: E(*), 0, F(#), D
- A second key pressed while in PRESSED or RELEASE is not reported. It is only reported if it is still down after release completes and the scan reaches it.

## Timing
- Reset values:
  - state: SCAN
  - `col_idx`: 0
  - `col_n`: 4'b1110
  - timers and counters: 0
  - `key_code`: 0
  - `key_valid`: 0
  - `key_held`: 0
  - synchronizer flops: 1
- Reset asserted mid-operation returns everything to these values immediately. No `key_valid` is emitted.
- Press latency:
  - 2 cycles synchronizer delay, plus up to 4·SCAN_DIV cycles to reach the column, plus DEBOUNCE_CYCLES cycles.
  - `key_valid` is registered: high the cycle after the final matching sample. `key_code` is valid in that same cycle.
- `key_valid` is never high for two consecutive cycles. At most one pulse per physical press.
- `key_held` falls the cycle after the DEBOUNCE_CYCLES-th release sample.
- Counters saturate-compare with `==`, and are sized to the parameter widths. No wrap occurs inside DEBOUNCE or RELEASE.

## Structure
- Package `keypad_pkg` holds:
  - the state enum: SCAN, DEBOUNCE, PRESSED, RELEASE
  - the 16-entry keymap constant indexed by `{row, col}`
  - the `ROWS` and `COLS` constants (4)
- Sub-module `sync_2ff`: 4-bit, reset-to-1 two-flop synchronizer.
- Everything else lives in one module: column timer, debounce counter, FSM, output registers.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_CYCLES=8.
- Reset: hold `rst_n`=0 → `col_n`=1110, `col_idx`=0, `key_valid`=0, `key_held`=0. After release, `col_idx` steps 0,1,2,3,0 every 4 cycles.
- Clean press: key "5" (row1/col1) held low for 40 cycles → exactly one `key_valid` pulse, `key_code`=4'h5, `key_held`=1. `col_idx` stays 1 until 8 cycles after release, then advances to 2.
- Bounce: row2/col3 toggled low/high every 3 cycles for 30 cycles, then held low → no pulse during the toggling. One pulse with `key_code`=4'hC after 8 stable cycles.
- Ghosting: rows 0 and 1 low together on col 0 → no `key_valid`, scanning continues.
- Release bounce: during RELEASE, row glitches low for 1 cycle → FSM returns to PRESSED, `key_held` stays 1, no second pulse.
- Async reset mid-DEBOUNCE: `rst_n` pulsed low for less than 1 cycle → outputs return to reset values immediately, no pulse emitted.
